// File: rtl/spi_pkg.sv
// Shared types and default sizing for the multi-slave SPI master.
package spi_pkg;

  localparam int DEF_DWIDTH    = 32;
  localparam int DEF_NSLAVES   = 4;
  localparam int DEF_DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period down-counter that toggles sclk every div+1
// clocks while enabled and flags which toggle is the leading or the trailing
// edge of the current bit.
module spi_sclk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic                 load_lvl,
  input  logic                 idle_lvl,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sclk,
  output logic                 lead_stb,
  output logic                 trail_stb
);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 phase;
  logic                 tick;

  assign tick      = en && (cnt == '0);
  assign lead_stb  = tick && !phase;
  assign trail_stb = tick && phase;

  // Reload the half-period counter while idle and toggle sclk on each expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt   <= div;
      phase <= 1'b0;
      sclk  <= load ? load_lvl : idle_lvl;
    end else if (tick) begin
      cnt   <= div;
      phase <= ~phase;
      sclk  <= ~sclk;
    end else begin
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: one request at a time, per-request slave, length,
// mode and SCLK divider, result returned on a single-cycle response strobe.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int NSLAVES      = DEF_NSLAVES,
  parameter int S_ADDR_WIDTH = (NSLAVES > 1) ? $clog2(NSLAVES) : 1,
  parameter int LEN_WIDTH    = (DWIDTH > 1) ? $clog2(DWIDTH) : 1,
  parameter int DIV_WIDTH    = DEF_DIV_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DWIDTH-1:0]       req_data,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [S_ADDR_WIDTH-1:0] req_slave,
  input  logic                    req_cpol,
  input  logic                    req_cpha,
  input  logic [DIV_WIDTH-1:0]    req_div,
  output logic                    rsp_valid,
  output logic [DWIDTH-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic [NSLAVES-1:0]      cs_n
);

  typedef struct packed {
    logic [DWIDTH-1:0]       data;
    logic [LEN_WIDTH-1:0]    len;
    logic [S_ADDR_WIDTH-1:0] slave;
    logic                    cpol;
    logic                    cpha;
    logic [DIV_WIDTH-1:0]    div;
  } spi_req_t;

  localparam logic [S_ADDR_WIDTH:0] NSLAVES_L = (S_ADDR_WIDTH + 1)'(NSLAVES);

  spi_state_e           state;
  spi_req_t             req_q;
  logic [DIV_WIDTH-1:0] wait_cnt;
  logic [LEN_WIDTH-1:0] bit_cnt;
  logic [DWIDTH-1:0]    rx_q;
  logic                 err_q;
  logic                 accept;
  logic                 slave_bad;
  logic                 lead_stb;
  logic                 trail_stb;

  // Active-low one-hot chip select; an out-of-range index selects nothing.
  function automatic logic [NSLAVES-1:0] cs_decode(input logic [S_ADDR_WIDTH-1:0] s);
    logic [NSLAVES-1:0] v;
    v = '1;
    for (int i = 0; i < NSLAVES; i++) begin
      if (s == S_ADDR_WIDTH'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign accept    = req_valid && req_ready;
  assign slave_bad = {1'b0, req_slave} >= NSLAVES_L;

  spi_sclk_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == SHIFT),
    .load      (accept),
    .load_lvl  (req_cpol),
    .idle_lvl  (req_q.cpol),
    .div       (req_q.div),
    .sclk      (sclk),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb)
  );

  // Transfer sequencer: latches the request, frames cs_n, shifts bits on the
  // SCLK strobes and publishes the response after the hold phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      wait_cnt  <= '0;
      bit_cnt   <= '0;
      rx_q      <= '0;
      err_q     <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= '1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_q.data  <= req_data;
            req_q.len   <= req_len;
            req_q.slave <= req_slave;
            req_q.cpol  <= req_cpol;
            req_q.cpha  <= req_cpha;
            req_q.div   <= req_div;
            wait_cnt    <= req_div;
            bit_cnt     <= req_len;
            rx_q        <= '0;
            err_q       <= slave_bad;
            cs_n        <= cs_decode(req_slave);
            if (!req_cpha) mosi <= req_data[req_len];
            busy        <= 1'b1;
            req_ready   <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (wait_cnt == '0) state <= SHIFT;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        SHIFT: begin
          if (lead_stb) begin
            if (req_q.cpha) mosi <= req_q.data[bit_cnt];
            else            rx_q <= {rx_q[DWIDTH-2:0], miso};
          end
          if (trail_stb) begin
            if (req_q.cpha)             rx_q <= {rx_q[DWIDTH-2:0], miso};
            else if (bit_cnt != '0)     mosi <= req_q.data[bit_cnt - 1'b1];
            if (bit_cnt == '0) begin
              wait_cnt <= req_q.div;
              state    <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt - 1'b1;
            end
          end
        end
        HOLD: begin
          if (wait_cnt == '0) begin
            cs_n  <= '1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= err_q ? '0 : rx_q;
          rsp_err   <= err_q;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
